pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the fixed 8-bit combinational adder chain.
- WIDTH-bit operands are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers its carry for the next stage.
- Valid/ready handshakes on input and output give full throughput with backpressure.
- Sits between operand-producing datapath logic and the result consumer (ALU/accumulator path).

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages; must divide WIDTH. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  operand A (unsigned/two's complement).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- Sub  input  1  0 = A+B+Cin; 1 = A−B−Cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  result, registered.
- Cout  output  1  carry-out (add) / NOT borrow-out (sub), registered.
- Ovf  output  1  signed overflow; present only with OVF_FLAG_EN.

Interface note:
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronously):
  - all stage valid bits cleared; Sum=0, Cout=0, out_valid=0, Ovf=0.
  - in_ready=0 while rst_n low; in_ready=1 in the first cycle after release.
  - in-flight beats are discarded, not completed.
- Operand preconditioning at accept:
  - B' = Sub ? ~B : B; c0 = Sub ? ~Cin : Cin.
  - Sub=1 thus computes A + ~B + ~Cin = A−B−Cin mod 2^WIDTH.
- Stage k (0..STAGES−1) holds a valid bit, result chunks 0..k, the carry out of chunk k, and unprocessed operand chunks k+1..STAGES−1.
- Stage k computes chunk k = A'[k] + B'[k] + carry from the previous stage's register (c0 for k=0), with a pure ripple inside the chunk.
- The last stage register drives Sum/Cout/out_valid directly; there is no combinational path from A/B to Sum.
- Transfers:
  - input transfer: in_valid & in_ready.
  - output transfer: out_valid & out_ready.
- Stage k advances when stage k+1 is empty or advancing; the last stage advances when out_ready is high or it is empty.
- in_ready = stage0 empty OR stage0 advancing. This is combinational on out_ready through the stall chain and is permitted.
- Latency: a beat accepted on edge n is visible at the output after edge n+STAGES−1. Throughput is 1 beat/cycle when out_ready stays high.
- Backpressure:
  - out_ready low with all stages full: in_ready=0, and Sum/Cout are held stable.
  - No beat is dropped or duplicated.
  - Simultaneous output pop and input push on a full pipe both succeed in the same cycle.
- Wrap-around: Sum is modulo 2^WIDTH; the overflow indication is Cout only.
- STAGES=1 degenerates to a single registered full-width adder with a skid-free handshake.
- Sub/Cin are sampled only at accept and travel with the beat; mixed add/sub streams are legal.

Optional Feature:
- Macro: OVF_FLAG_EN.
- Defined:
  - port Ovf exists.
  - Ovf = (A'[W−1] == B'[W−1]) & (Sum[W−1] != A'[W−1]), where A' and B' are the preconditioned operands; registered with the beat, valid with out_valid.
  - requires the MSB chunk's carry-into-MSB to be registered.
- Undefined: no Ovf port, no extra flops; behaviour is otherwise identical.

Decomposition:
- Package pipe_adder_pkg:
  - function chunk_width(WIDTH, STAGES).
  - typedef for a stage record {valid, carry, sub, data}.
  - localparam checks (WIDTH % STAGES == 0).
- Sub-module adder_slice:
  - CW-bit combinational ripple (Sum chunk, Cout) from per-bit full-adder cells.
  - instantiated STAGES times.
- Stage registers and handshake live in pipe_adder.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1. Push A=0x0000_00FF, B=0x0000_0001, Cin=0, Sub=0 → after 4 cycles Sum=0x0000_0100, Cout=0, out_valid for exactly 1 cycle.
- Carry across every chunk. Push A=0xFFFF_FFFF, B=0, Cin=1, Sub=0 → Sum=0x0000_0000, Cout=1 (with OVF_FLAG_EN: Ovf=0).
- Subtract. Push A=5, B=7, Cin=0, Sub=1 → Sum=0xFFFF_FFFE, Cout=0 (borrow). Then A=0x8000_0000, B=1, Sub=1 → Sum=0x7FFF_FFFF, Cout=1, Ovf=1 when enabled.
- Backpressure:
  - stream 10 random beats with out_ready toggling 1010… and held low for 6 cycles.
  - Results must arrive in order and match a reference model; Sum is stable while out_valid & ~out_ready.
  - in_ready falls once 4 beats are held.
- Reset mid-operation. Assert rst_n=0 with 3 beats in flight → out_valid=0, Sum=0 immediately. After release, no stale beat emerges and the first new beat is correct.
- STAGES=1 and STAGES=8 (WIDTH=32) builds: back-to-back random beats at full rate → latency 1 and 8 respectively, all results correct.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types and configuration helpers for pipe_adder and its ripple slices.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Control half of a stage record; pipe_adder pairs it with a WIDTH-bit data field.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
  } stage_ctl_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// CW-bit combinational ripple-carry chunk built from per-bit full-adder cells.
module adder_slice #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout
);

  // Returns {carry_out, sum} of one bit position.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  always_comb begin
    logic       c;
    logic [1:0] r;
    s = '0;
    c = cin;
    r = '0;
    for (int i = 0; i < CW; i++) begin
      r    = fa(a[i], b[i], c);
      s[i] = r[0];
      c    = r[1];
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides.
// Optional signed-overflow output is enabled by defining OVF_FLAG_EN.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef OVF_FLAG_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be >= 1 and a multiple of STAGES");
  end

  // data holds finished result chunks 0..k and raw A chunks above k.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] data;
  } stage_t;

  function automatic logic [CW-1:0] precond(input logic [CW-1:0] b, input logic sub);
    return sub ? ~b : b;
  endfunction

  stage_t            st_p     [STAGES];
  logic [WIDTH-1:0]  b_p      [STAGES];
  stage_t            up       [STAGES];
  logic [WIDTH-1:0]  up_b     [STAGES];
  logic [WIDTH-1:0]  nxt_data [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] cin_all;
  logic [STAGES-1:0] co_all;
  logic [WIDTH-1:0]  a_op;
  logic [WIDTH-1:0]  b_op;
  logic [WIDTH-1:0]  s_all;

  // A stage may take new contents when it is empty or its successor moves on.
  always_comb begin
    logic go;
    adv = '0;
    go  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go     = ~st_p[k].ctl.valid | go;
      adv[k] = go;
    end
  end

  assign in_ready = rst_n & adv[0];

  always_comb begin
    up[0].ctl.valid = in_valid;
    up[0].ctl.carry = Sub ^ Cin;
    up[0].ctl.sub   = Sub;
    up[0].data      = A;
    up_b[0]         = B;
    for (int k = 1; k < STAGES; k++) begin
      up[k]   = st_p[k-1];
      up_b[k] = b_p[k-1];
    end
  end

  // B is inverted chunk by chunk as it is consumed; Sub travels with the beat.
  always_comb begin
    a_op    = '0;
    b_op    = '0;
    cin_all = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_op[k*CW +: CW] = up[k].data[k*CW +: CW];
      b_op[k*CW +: CW] = precond(up_b[k][k*CW +: CW], up[k].ctl.sub);
      cin_all[k]       = up[k].ctl.carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.CW(CW)) u_slice (
      .a    (a_op[k*CW +: CW]),
      .b    (b_op[k*CW +: CW]),
      .cin  (cin_all[k]),
      .s    (s_all[k*CW +: CW]),
      .cout (co_all[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_data[k]              = up[k].data;
      nxt_data[k][k*CW +: CW]  = s_all[k*CW +: CW];
    end
  end

  // ---- stage registers: stage k latches chunk k and its carry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_p[k] <= '0;
        b_p[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          st_p[k].ctl.valid <= up[k].ctl.valid;
          if (up[k].ctl.valid) begin
            st_p[k].ctl.carry <= co_all[k];
            st_p[k].ctl.sub   <= up[k].ctl.sub;
            st_p[k].data      <= nxt_data[k];
            b_p[k]            <= up_b[k];
          end
        end
      end
    end
  end

`ifdef OVF_FLAG_EN
  logic ovf_nxt;
  logic ovf_p;

  assign ovf_nxt = (a_op[WIDTH-1] == b_op[WIDTH-1]) & (s_all[WIDTH-1] != a_op[WIDTH-1]);

  // ---- overflow flag rides with the beat into the last stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p <= 1'b0;
    end else if (adv[STAGES-1] && up[STAGES-1].ctl.valid) begin
      ovf_p <= ovf_nxt;
    end
  end

  assign Ovf = ovf_p;
`endif

  assign out_valid = st_p[STAGES-1].ctl.valid;
  assign Sum       = st_p[STAGES-1].data;
  assign Cout      = st_p[STAGES-1].ctl.carry;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (STAGES=4 main instance, plus STAGES=1 and 8).
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout;
  logic [31:0] A, B, Sum;
  logic        x_valid, x_Cin, x_Sub, x_ready;
  logic [31:0] x_A, x_B;
  logic        r1, v1, c1, r8, v8, c8;
  logic [31:0] s1, s8;
`ifdef OVF_FLAG_EN
  logic        Ovf, o1, o8;
`endif

  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout)
`ifdef OVF_FLAG_EN
    , .Ovf(Ovf)
`endif
  );

  pipe_adder #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r1),
    .A(x_A), .B(x_B), .Cin(x_Cin), .Sub(x_Sub), .out_valid(v1), .out_ready(x_ready),
    .Sum(s1), .Cout(c1)
`ifdef OVF_FLAG_EN
    , .Ovf(o1)
`endif
  );

  pipe_adder #(.WIDTH(32), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r8),
    .A(x_A), .B(x_B), .Cin(x_Cin), .Sub(x_Sub), .out_valid(v8), .out_ready(x_ready),
    .Sum(s8), .Cout(c8)
`ifdef OVF_FLAG_EN
    , .Ovf(o8)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Hand-computed vectors: Sum = A + B + Cin (Sub=0) or A - B - Cin (Sub=1), mod 2^32.
  logic [31:0] tv_a [10] = '{32'h0000_0001, 32'hFFFF_0000, 32'h1234_5678, 32'h0000_0010, 32'h0000_0000,
                             32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0100, 32'h8000_0000, 32'h00FF_00FF};
  logic [31:0] tv_b [10] = '{32'h0000_0002, 32'h0001_0000, 32'h1111_1111, 32'h0000_0010, 32'h0000_0001,
                             32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFF00_FF00};
  logic [31:0] tv_s [10] = '{32'h0000_0003, 32'h0000_0000, 32'h2345_678A, 32'h0000_0000, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_00FE, 32'h0000_0000, 32'hFFFF_FFFF};
  logic [9:0]  tv_cin  = 10'b0010000100;
  logic [9:0]  tv_sub  = 10'b0010011000;
  logic [9:0]  tv_cout = 10'b0110001010;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    in_valid = v; A = a; B = b; Cin = c; Sub = s;
  endtask

  task automatic xdrive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s);
    x_valid = v; x_A = a; x_B = b; x_Cin = c; x_Sub = s;
  endtask

  // One isolated beat on the 4-stage instance: visible only after the 3rd edge past accept.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [31:0] es,
                        input logic ec, input logic eo);
    drive(1'b1, a, b, c, s);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk({tag, "_early"}, out_valid, 1'b0);
    tick();
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_sum"}, Sum, es);
    chk({tag, "_cout"}, Cout, ec);
`ifdef OVF_FLAG_EN
    chk({tag, "_ovf"}, Ovf, eo);
`endif
    tick();
    chk({tag, "_once"}, out_valid, 1'b0);
  endtask

  task automatic chk_lane(input string tag, input logic v, input logic [31:0] s,
                          input logic co, input int idx);
    if (idx >= 0 && idx < 4) begin
      chk($sformatf("%s_vld%0d", tag, idx), v, 1'b1);
      chk($sformatf("%s_sum%0d", tag, idx), s, tv_s[idx]);
      chk($sformatf("%s_cout%0d", tag, idx), co, tv_cout[idx]);
    end else begin
      chk($sformatf("%s_idle", tag), v, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent, rcv;
    logic        held_v, stale;
    logic [31:0] held_sum;

    rst_n = 1'b0;
    out_ready = 1'b1;
    x_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    xdrive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", Sum, 32'h0);
    chk("rst_cout", Cout, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    tick();

    single("add_ff", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    single("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single("sub_bin", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);

    // Full rate on all three depths: 4 back-to-back beats, latency 4/1/8 edges.
    for (int c = 0; c < 13; c++) begin
      if (c < 4) begin
        drive(1'b1, tv_a[c], tv_b[c], tv_cin[c], tv_sub[c]);
        xdrive(1'b1, tv_a[c], tv_b[c], tv_cin[c], tv_sub[c]);
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        xdrive(1'b0, '0, '0, 1'b0, 1'b0);
      end
      tick();
      chk_lane("fr4", out_valid, Sum, Cout, c - 3);
      chk_lane("fr1", v1, s1, c1, c);
      chk_lane("fr8", v8, s8, c8, c - 7);
    end

    // Backpressure: out_ready low 6 cycles, then toggling 1010...
    sent = 0;
    rcv = 0;
    held_v = 1'b0;
    held_sum = '0;
    for (int cyc = 0; cyc < 80 && rcv < 10; cyc++) begin
      out_ready = (cyc < 6) ? 1'b0 : ((cyc % 2) == 0);
      if (sent < 10) drive(1'b1, tv_a[sent], tv_b[sent], tv_cin[sent], tv_sub[sent]);
      else drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (held_v) begin
        chk("bp_hold_vld", out_valid, 1'b1);
        chk("bp_hold_sum", Sum, held_sum);
      end
      if (cyc == 3) chk("bp_inrdy_fill", in_ready, 1'b1);
      if (cyc == 4) chk("bp_inrdy_full", in_ready, 1'b0);
      if (cyc == 5) chk("bp_inrdy_full2", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_sum%0d", rcv), Sum, tv_s[rcv]);
        chk($sformatf("bp_cout%0d", rcv), Cout, tv_cout[rcv]);
        rcv++;
      end
      held_v = out_valid && !out_ready;
      held_sum = Sum;
      if (in_valid && in_ready) sent++;
      tick();
    end
    chk("bp_count", rcv, 10);
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // Reset with beats in flight.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, tv_a[c + 4], tv_b[c + 4], tv_cin[c + 4], tv_sub[c + 4]);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("mid_pre_vld", out_valid, 1'b1);
    chk("mid_pre_sum", Sum, tv_s[4]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_sum", Sum, 32'h0);
    chk("mid_rst_inrdy", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    chk("mid_no_stale", stale, 1'b0);
    single("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
